// File: rtl/kbd_disp_ctrl.sv
// kbd_disp_ctrl: PS/2 scan-code sequencer to seven-segment display state; KBD_REPEAT_CNT_EN makes repeats count
module kbd_disp_ctrl #(
  parameter int TIMEOUT = 100000,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [7:0]       kb_data,
  input  logic             kb_valid,
  output logic             kb_ready,
  output logic [15:0]      disp_data,
  output logic             disp_blank,
  output logic [CNT_W-1:0] press_cnt,
  output logic             seq_err
);
  localparam int TW = $clog2(TIMEOUT + 1);
  typedef enum logic [2:0] {IDLE, EXT, BRK, EXT_BRK, ACK} state_t;
  state_t state, nxt;
  logic [TW-1:0] timer, timer_nxt;
  logic [15:0] held, held_nxt, disp_nxt, key;
  logic held_vld, held_vld_nxt, err_nxt, acc, is_e0, is_f0, prefix, make, brk, same;
  logic [CNT_W-1:0] cnt_nxt;
  assign disp_blank = !held_vld;
  // decode the accepted byte against the prefix state and compute all next values
  always_comb begin
    acc = kb_valid && kb_ready;
    is_e0 = kb_data == 8'hE0;
    is_f0 = kb_data == 8'hF0;
    prefix = state == EXT || state == BRK || state == EXT_BRK;
    key = {(state == EXT || state == EXT_BRK) ? 8'hE0 : 8'h00, kb_data};
    same = held_vld && held == key;
    nxt = state;
    timer_nxt = timer;
    held_nxt = held;
    held_vld_nxt = held_vld;
    disp_nxt = disp_data;
    cnt_nxt = press_cnt;
    err_nxt = 1'b0;
    make = 1'b0;
    brk = 1'b0;
    if (state == ACK) begin
      nxt = IDLE;
    end else if (acc) begin
      if (state == IDLE) begin
        nxt = is_e0 ? EXT : is_f0 ? BRK : ACK;
        make = !is_e0 && !is_f0;
      end else if (state == EXT) begin
        nxt = is_f0 ? EXT_BRK : is_e0 ? EXT : ACK;
        err_nxt = is_e0;
        make = !is_e0 && !is_f0;
      end else begin
        nxt = (is_e0 || is_f0) ? IDLE : ACK;
        err_nxt = is_e0 || is_f0;
        brk = !is_e0 && !is_f0;
      end
      timer_nxt = (nxt == EXT || nxt == BRK || nxt == EXT_BRK) ? TW'(TIMEOUT - 1) : timer;
    end else if (prefix) begin
      nxt = (timer == '0) ? IDLE : state;
      err_nxt = timer == '0;
      timer_nxt = (timer == '0) ? timer : timer - 1'b1;
    end
    if (make && !same) begin
      held_nxt = key;
      held_vld_nxt = 1'b1;
      disp_nxt = key;
      cnt_nxt = press_cnt + 1'b1;
    end
`ifdef KBD_REPEAT_CNT_EN
    if (make && same) cnt_nxt = press_cnt + 1'b1;
`else
`endif
    if (brk && same) held_vld_nxt = 1'b0;
  end
  // register state and outputs; kb_ready is held low through reset and ACK
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      timer <= '0;
      held <= '0;
      held_vld <= 1'b0;
      disp_data <= '0;
      press_cnt <= '0;
      seq_err <= 1'b0;
      kb_ready <= 1'b0;
    end else begin
      state <= nxt;
      timer <= timer_nxt;
      held <= held_nxt;
      held_vld <= held_vld_nxt;
      disp_data <= disp_nxt;
      press_cnt <= cnt_nxt;
      seq_err <= err_nxt;
      kb_ready <= nxt != ACK;
    end
  end
endmodule
